// File: rtl/rom_dl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rom_dl_pkg                                                                  |
// | Shared types and default limits for the ROM download controller.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package rom_dl_pkg;

  localparam int DL_AW = 17;

  localparam logic [DL_AW-1:0] ROM_MIN_DEF = 17'h08000;
  localparam logic [DL_AW-1:0] ROM_MAX_DEF = 17'h10000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } dl_state_t;

endpackage
`default_nettype wire

// File: rtl/rst_stretch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rst_stretch                                                                 |
// | Loadable down-counter; o_done is high once the loaded count has expired.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rst_stretch #(
  parameter int WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rom_dl_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rom_dl_ctrl                                                                 |
// | Filters the ioctl stream for the game ROM, re-times it onto the core's      |
// | download port, validates the image and owns rom_loaded / core_reset.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter logic [7:0]       ROM_INDEX = 8'd0,
  parameter logic [DL_AW-1:0] MIN_BYTES = ROM_MIN_DEF,
  parameter logic [DL_AW-1:0] MAX_BYTES = ROM_MAX_DEF,
  parameter int               RST_HOLD  = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             user_rst,
  input  logic             ioctl_downl,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic [15:0]      dn_addr,
  output logic [7:0]       dn_data,
  output logic             dn_wr,
  output logic             core_reset,
  output logic             rom_loaded,
  output logic             load_error,
  output logic [DL_AW-1:0] byte_count
);

  localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  dl_state_t        r_state;
  dl_state_t        w_state_nxt;
  logic             r_downl_d;
  logic             r_stale;
  logic [DL_AW-1:0] r_byte_count;
  logic [DL_AW-1:0] w_count_nxt;
  logic             r_load_error;
  logic             w_err_nxt;
  logic             r_rom_loaded;
  logic             w_loaded_nxt;
  logic             r_core_reset;
  logic             w_core_reset_nxt;
  logic [15:0]      r_dn_addr;
  logic [7:0]       r_dn_data;
  logic             r_dn_wr;

  logic             w_start;
  logic             w_end;
  logic             w_end_ok;
  logic             w_wr_load;
  logic             w_addr_ok;
  logic             w_accept;
  logic             w_hold_load;
  logic [HOLD_W-1:0] w_hold_val;
  logic             w_hold_done;

  // A download already in flight when reset releases is not taken as a new start.
  assign w_start   = !r_downl_d && ioctl_downl && (ioctl_index == ROM_INDEX) && !r_stale;
  assign w_end     = r_downl_d && !ioctl_downl && (r_state == LOAD);
  assign w_end_ok  = w_end && (r_byte_count >= MIN_BYTES) && !r_load_error;
  assign w_wr_load = (r_state == LOAD) && ioctl_wr && ioctl_downl && !w_start;
  assign w_addr_ok = (ioctl_addr < {8'd0, MAX_BYTES}) &&
                     (ioctl_addr == {8'd0, r_byte_count});
  assign w_accept  = w_wr_load && w_addr_ok;

  assign w_hold_load = w_end_ok || w_start;
  assign w_hold_val  = w_end_ok ? HOLD_W'(RST_HOLD) : '0;

  rst_stretch #(
    .WIDTH (HOLD_W)
  ) u_hold (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .i_load     (w_hold_load),
    .i_load_val (w_hold_val),
    .o_done     (w_hold_done)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_byte_count;
    w_err_nxt    = r_load_error;
    w_loaded_nxt = r_rom_loaded;

    if (w_start) begin
      w_state_nxt  = LOAD;
      w_count_nxt  = '0;
      w_err_nxt    = 1'b0;
      w_loaded_nxt = 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_end) begin
            if (w_end_ok) begin
              w_state_nxt = HOLD;
            end else begin
              w_state_nxt = ERR;
              w_err_nxt   = 1'b1;
            end
          end else if (w_wr_load) begin
            if (w_addr_ok) begin
              w_count_nxt = (r_byte_count == '1) ? r_byte_count : r_byte_count + 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_hold_done) begin
            w_state_nxt  = RUN;
            w_loaded_nxt = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    // Foreign-index downloads also hold the core in reset while they run.
    w_core_reset_nxt = (w_state_nxt == RUN) ? (user_rst || ioctl_downl) : 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= IDLE;
      r_downl_d    <= 1'b0;
      r_stale      <= ioctl_downl;
      r_byte_count <= '0;
      r_load_error <= 1'b0;
      r_rom_loaded <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_downl_d    <= ioctl_downl;
      r_byte_count <= w_count_nxt;
      r_load_error <= w_err_nxt;
      r_rom_loaded <= w_loaded_nxt;
      r_core_reset <= w_core_reset_nxt;
      if (!ioctl_downl) begin
        r_stale <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dn_wr   <= 1'b0;
      r_dn_addr <= '0;
      r_dn_data <= '0;
    end else begin
      r_dn_wr <= w_accept;
      if (w_accept) begin
        r_dn_addr <= ioctl_addr[15:0];
        r_dn_data <= ioctl_dout;
      end
    end
  end

  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_wr      = r_dn_wr;
  assign core_reset = r_core_reset;
  assign rom_loaded = r_rom_loaded;
  assign load_error = r_load_error;
  assign byte_count = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rom_dl_ctrl                                                              |
// | Self-checking bench: cycle model, vector table and directed sequences.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rom_dl_ctrl;

  localparam logic [16:0] MIN_B  = 17'h08000;
  localparam logic [16:0] MAX_B  = 17'h10000;
  localparam int          HOLD_N = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_ERR = 4;

  logic        clk_sys = 1'b0;
  logic        reset, user_rst, ioctl_downl, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr, core_reset, rom_loaded, load_error;
  logic [16:0] byte_count;

  always #5 clk_sys = ~clk_sys;

  rom_dl_ctrl #(
    .ROM_INDEX (8'd0),
    .MIN_BYTES (MIN_B),
    .MAX_BYTES (MAX_B),
    .RST_HOLD  (HOLD_N)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .user_rst    (user_rst),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wr       (dn_wr),
    .core_reset  (core_reset),
    .rom_loaded  (rom_loaded),
    .load_error  (load_error),
    .byte_count  (byte_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int edge_no  = 0;

  // Reference model: phase, accepted count, error flag, and the edge of the end event.
  int          m_phase = P_IDLE;
  int          m_count = 0;
  int          m_end_edge = 0;
  bit          m_err = 0, m_loaded = 0, m_downl_d = 0, m_stale = 0, m_core_reset = 1;
  bit          e_wr = 0;
  logic [15:0] e_addr = '0;
  logic [7:0]  e_data = '0;

  typedef struct {
    logic       ur;
    logic       dl;
    logic [7:0] ix;
    logic       cr;
    logic       rl;
  } run_vec_t;

  run_vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic model_edge();
    bit start, fin;
    edge_no++;
    e_wr = 0;
    if (reset) begin
      m_phase = P_IDLE; m_count = 0; m_err = 0; m_loaded = 0;
      m_downl_d = 0; m_stale = ioctl_downl; m_core_reset = 1;
    end else begin
      start = !m_downl_d && ioctl_downl && (ioctl_index == 8'd0) && !m_stale;
      fin   = m_downl_d && !ioctl_downl && (m_phase == P_LOAD);
      if (start) begin
        m_phase = P_LOAD; m_count = 0; m_err = 0; m_loaded = 0;
      end else if (fin) begin
        if (m_count >= int'(MIN_B) && !m_err) begin
          m_phase = P_HOLD; m_end_edge = edge_no;
        end else begin
          m_phase = P_ERR; m_err = 1;
        end
      end else if (m_phase == P_LOAD && ioctl_wr && ioctl_downl) begin
        if (int'(ioctl_addr) < int'(MAX_B) && int'(ioctl_addr) == m_count) begin
          e_wr = 1; e_addr = ioctl_addr[15:0]; e_data = ioctl_dout;
          if (m_count < 'h1FFFF) m_count++;
        end else begin
          m_err = 1;
        end
      end else if (m_phase == P_HOLD && edge_no == m_end_edge + HOLD_N + 1) begin
        m_phase = P_RUN; m_loaded = 1;
      end
      if (!ioctl_downl) m_stale = 0;
      m_downl_d = ioctl_downl;
      m_core_reset = (m_phase == P_RUN) ? (user_rst | ioctl_downl) : 1'b1;
    end
  endtask

  task automatic step();
    logic [44:0] act, exp;
    model_edge();
    @(posedge clk_sys);
    #1;
    if (dn_wr === 1'b1) n_pulses++;
    act = {dn_wr, e_wr ? dn_addr : 16'h0, e_wr ? dn_data : 8'h0,
           core_reset, rom_loaded, load_error, byte_count};
    exp = {e_wr, e_wr ? e_addr : 16'h0, e_wr ? e_data : 8'h0,
           m_core_reset, m_loaded, m_err, 17'(m_count)};
    chk("cycle", 64'(act), 64'(exp));
  endtask

  task automatic idle(input int n);
    ioctl_wr = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_downl = 1; ioctl_wr = 0;
    step();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1;
    step();
    ioctl_wr = 0;
  endtask

  task automatic end_dl();
    ioctl_downl = 0; ioctl_wr = 0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a, n, r;
    tbl[0] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 8'd1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1};

    reset = 1; user_rst = 0; ioctl_downl = 0; ioctl_index = 0;
    ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
    idle(3);
    reset = 0;
    chk("reset_core_reset", core_reset, 1);
    chk("reset_rom_loaded", rom_loaded, 0);
    chk("reset_byte_count", byte_count, 0);
    ioctl_addr = 0; ioctl_wr = 1;
    for (int i = 0; i < 3; i++) step();
    idle(20);
    chk("idle_no_dn_wr", n_pulses, 0);
    chk("idle_core_reset", core_reset, 1);

    // Byte 0x1234 missing: every later byte is refused.
    start_dl(8'd0);
    for (int k = 0; k <= 'h1240; k++)
      if (k != 'h1234) wr_byte(25'(k), 8'(k));
    chk("skip_pulses", n_pulses, 'h1234);
    end_dl();
    idle(20);
    chk("skip_load_error", load_error, 1);
    chk("skip_core_reset", core_reset, 1);
    chk("skip_rom_loaded", rom_loaded, 0);

    // Short image.
    start_dl(8'd0);
    for (int k = 0; k < 'h4000; k++) wr_byte(25'(k), 8'(k));
    end_dl();
    idle(20);
    chk("short_rom_loaded", rom_loaded, 0);
    chk("short_load_error", load_error, 1);
    chk("short_byte_count", byte_count, 'h4000);

    // Full image, back-to-back strobes, then the hold timing.
    n_pulses = 0;
    start_dl(8'd0);
    for (int k = 0; k < 'h8000; k++) wr_byte(25'(k), 8'(k));
    end_dl();
    chk("full_pulses", n_pulses, 'h8000);
    chk("full_byte_count", byte_count, 'h8000);
    repeat (HOLD_N) step();
    chk("hold_e16_rom_loaded", rom_loaded, 0);
    chk("hold_e16_core_reset", core_reset, 1);
    step();
    chk("hold_e17_rom_loaded", rom_loaded, 1);
    chk("hold_e17_core_reset", core_reset, 0);
    chk("full_load_error", load_error, 0);

    for (int i = 0; i < 10; i++) begin
      user_rst = tbl[i].ur; ioctl_downl = tbl[i].dl; ioctl_index = tbl[i].ix; ioctl_wr = 0;
      step();
      chk("tbl_core_reset", core_reset, tbl[i].cr);
      chk("tbl_rom_loaded", rom_loaded, tbl[i].rl);
      chk("tbl_dn_wr", dn_wr, 0);
    end

    // Foreign-index download while running.
    p0 = n_pulses;
    start_dl(8'd1);
    for (int k = 0; k < 16; k++) begin
      wr_byte(25'(k), 8'($urandom));
      chk("idx1_core_reset", core_reset, 1);
    end
    end_dl();
    chk("idx1_no_dn_wr", n_pulses, p0);
    chk("idx1_rom_loaded", rom_loaded, 1);
    chk("idx1_core_reset_after", core_reset, 0);

    // Randomized downloads, gaps, stray addresses, user and block resets.
    for (int it = 0; it < 40; it++) begin
      ioctl_index = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
      if ($urandom_range(0, 9) == 0) ioctl_index = 8'($urandom_range(2, 255));
      user_rst = ($urandom_range(0, 9) == 0);
      ioctl_downl = 1; ioctl_wr = 0;
      step();
      n = $urandom_range(0, 60);
      a = 0;
      for (int j = 0; j < n; j++) begin
        user_rst = ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 99);
        if (r < 5)      ioctl_addr = 25'($urandom_range(0, a + 3));
        else if (r < 8) ioctl_addr = 25'('h10000 + $urandom_range(0, 4));
        else            ioctl_addr = 25'(a);
        ioctl_dout = 8'($urandom);
        ioctl_wr = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 199) == 0);
        step();
        if (ioctl_wr && int'(ioctl_addr) == a) a++;
      end
      reset = 0; ioctl_downl = 0; ioctl_wr = 0;
      n = $urandom_range(1, 20);
      for (int j = 0; j < n; j++) begin
        user_rst = ($urandom_range(0, 9) == 0);
        ioctl_wr = ($urandom_range(0, 4) == 0);
        ioctl_addr = 25'($urandom_range(0, 3));
        step();
      end
    end
    user_rst = 0;
    idle(3);

    // Address at the limit.
    start_dl(8'd0);
    for (int k = 0; k < 3; k++) wr_byte(25'(k), 8'(k));
    p0 = n_pulses;
    wr_byte(25'h10000, 8'hAA);
    chk("oob_no_dn_wr", n_pulses, p0);
    chk("oob_load_error", load_error, 1);
    chk("oob_byte_count", byte_count, 3);
    end_dl();
    idle(3);

    // Block reset in the middle of a load.
    start_dl(8'd0);
    for (int k = 0; k < 10; k++) wr_byte(25'(k), 8'(k));
    reset = 1;
    step();
    reset = 0;
    chk("rst_byte_count", byte_count, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_loaded", rom_loaded, 0);
    p0 = n_pulses;
    for (int k = 10; k < 20; k++) wr_byte(25'(k), 8'(k));
    chk("rst_no_dn_wr", n_pulses, p0);
    chk("rst_byte_count_after", byte_count, 0);
    end_dl();
    idle(5);
    chk("rst_load_error", load_error, 0);
    chk("rst_core_reset_after", core_reset, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_dl_ctrl.md
# rom_dl_ctrl

Download controller between `data_io` and the `pacman` core. Filters the ioctl byte stream for the game ROM index and re-times it onto the core's `dn_addr`/`dn_data`/`dn_wr` port. Validates the image as contiguous and within size limits. Owns the `rom_loaded` flag and the core reset, replacing the ad-hoc reset logic in the top level.

## Interface
Parameters:
- `ROM_INDEX`, 8'd0: ioctl_index value carrying the game ROM.
- `MIN_BYTES`, 17'h08000: minimum byte count for a valid image.
- `MAX_BYTES`, 17'h10000: address limit; bytes at or above it are rejected.
- `RST_HOLD`, 16: cycles core reset stays asserted after a good download.

Ports:
- `clk_sys` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high block reset (PLL-lock based); clears all state including `rom_loaded`.
- `user_rst` in 1: user reset request (status[0] | buttons[1]); affects `core_reset` only.
- `ioctl_downl` in 1: download active.
- `ioctl_index` in 8: download target index.
- `ioctl_wr` in 1: byte strobe.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `dn_addr` out 16: registered write address to the core.
- `dn_data` out 8: registered write data to the core.
- `dn_wr` out 1: one-cycle write strobe.
- `core_reset` out 1: reset to the core.
- `rom_loaded` out 1: a valid image is resident.
- `load_error` out 1: the last ROM download failed.
- `byte_count` out 17: bytes accepted in the current or last download.

## Operation
- The shared package defines the state enum `dl_state_t`: IDLE, LOAD, HOLD, RUN, ERR.
- Reset values:
  - state=IDLE.
  - `core_reset`=1, `rom_loaded`=0, `load_error`=0.
  - `dn_wr`=0, `dn_addr`=0, `dn_data`=0.
  - `byte_count`=0.
  - registered `downl_d`=0.
- Start event: `downl_d`=0, `ioctl_downl`=1 and `ioctl_index`==ROM_INDEX. Taken from any state:
  - go to LOAD;
  - clear `byte_count` and `load_error`;
  - `rom_loaded`<=0.
- LOAD, on each `ioctl_wr` with `ioctl_downl`=1:
  - Accept only if `ioctl_addr`<MAX_BYTES and `ioctl_addr`==`byte_count` (contiguity check).
  - Accepted: `dn_addr`<=`ioctl_addr[15:0]`, `dn_data`<=`ioctl_dout`, `dn_wr`<=1, `byte_count`+1.
  - Rejected: no `dn_wr`; `load_error`<=1 (sticky until the next start).
- End event: `downl_d`=1, `ioctl_downl`=0, in LOAD.
  - If `byte_count`>=MIN_BYTES and `load_error`=0: go to HOLD and load the hold counter with RST_HOLD.
  - Otherwise: `load_error`<=1 and go to ERR.
- HOLD: the counter decrements each cycle. At 0, go to RUN and set `rom_loaded`<=1.
- RUN: `core_reset`<=`user_rst`.
- ERR: `core_reset`=1 and `rom_loaded`=0 until the next start event.
- Downloads with another index:
  - never produce `dn_wr`;
  - do not change state;
  - force `core_reset`=1 while `ioctl_downl`=1.
- `ioctl_wr` with `ioctl_downl`=0 is ignored.
- `byte_count` saturates at 17'h1FFFF.

## Timing
- `dn_*` outputs have 1-cycle latency: `ioctl_wr` sampled at edge N gives `dn_wr`=1 during cycle N+1 only.
- The write strobe is never stretched. Back-to-back `ioctl_wr` on consecutive cycles gives back-to-back `dn_wr`.
- A write and the end condition in adjacent cycles: the write counts. The end event is detected from `downl_d`, one cycle after `ioctl_downl` falls.
- Let E be the edge at which the end event is sampled. Then `rom_loaded` rises and `core_reset` falls (if `user_rst`=0) at edge E+RST_HOLD+1.
- `core_reset` is registered and follows `user_rst` with 1-cycle latency in RUN.
- A start event mid-LOAD restarts the count. A start event in HOLD aborts the hold.
- `reset` mid-download returns to IDLE. Later writes of that download are ignored until a fresh start event.

## Structure
- Package `rom_dl_pkg` holds:
  - `dl_state_t`;
  - address width constant `DL_AW`=17;
  - default limits `ROM_MIN_DEF` and `ROM_MAX_DEF`.
- Sub-module `rst_stretch`: a loadable down-counter producing the HOLD-phase reset. It is reused by other cores.
- Everything else lives in a single always block for the FSM plus a registered output stage.

## Test plan
- Reset then idle → `core_reset`=1, `rom_loaded`=0, `dn_wr` never asserts.
- Index 0, 0x8000 contiguous bytes, addr/data=k/k[7:0] → exactly 0x8000 `dn_wr` pulses, each 1 cycle after `ioctl_wr`; `byte_count`=0x8000; `rom_loaded`=1 at E+17; `load_error`=0.
- Index 0 with byte 0x1234 skipped → no `dn_wr` for 0x1235 onward; at end state=ERR, `load_error`=1, `core_reset` stays 1.
- Index 0, only 0x4000 bytes → ERR, `rom_loaded`=0. Then a full 0x8000-byte reload → RUN, `load_error`=0.
- In RUN, `user_rst` pulsed 3 cycles → `core_reset` high for 3 cycles, delayed 1; `rom_loaded` stays 1. An index-1 download of 16 bytes → no `dn_wr`, `core_reset`=1 during it, `rom_loaded` stays 1.
- Byte at addr 0x10000 → rejected, `load_error`=1. `reset` asserted mid-LOAD → IDLE, `byte_count`=0, remaining writes ignored.
